// File: rtl/imu_ball_renderer.sv
// ---------------------------------------------------------------------------
// imu_ball_renderer
//
// Purpose:
//   This is the upstream stage of the LED-strip driver. Once per frame it
//   integrates IMU acceleration into a ball velocity and position on a 16x16
//   matrix. It then renders the ball as a single lit pixel into a 256-bit
//   bitmap. Rendering goes into a shadow buffer. The buffer is copied to the
//   output in one edge, so the driver never sees a partly drawn frame.
//
// Ports:
//   clock        in   1    system clock
//   reset        in   1    asynchronous, active-high reset
//   imu_data     in   96   [95:80] accel X (signed, column), [79:64] accel Y
//                          (signed, row), [63:0] unused
//   imu_valid    in   1    captures imu_data into the hold register
//   frame_tick   in   1    single-cycle request to compute a new frame
//   matrix       out  256  committed bitmap, bit (row*16+col) = pixel lit
//   matrix_valid out  1    one-cycle pulse on the edge matrix updates
//   busy         out  1    high while a frame is being computed
//
// Optional feature macro: DEADZONE_EN
//   When this macro is defined, an axis whose raw accel magnitude is within
//   DEADZONE is treated as having zero accel. On that axis the velocity
//   also decays toward zero by a quarter each frame (friction).
// ---------------------------------------------------------------------------
module imu_ball_renderer #(
  parameter int FRAC_W      = 8,
  parameter int VEL_W       = 12,
  parameter int ACCEL_SHIFT = 6,
  parameter int VMAX        = 255,
  parameter int DEADZONE    = 512
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [95:0]  imu_data,
  input  logic         imu_valid,
  input  logic         frame_tick,
  output logic [255:0] matrix,
  output logic         matrix_valid,
  output logic         busy
);

  localparam int POS_W  = 4 + FRAC_W;
  // The velocity sum needs VEL_W+2 bits. It must also be wide enough to
  // hold the shifted 16-bit accel without truncating it.
  localparam int SUM_W  = (VEL_W + 2 > 17) ? VEL_W + 2 : 17;
  localparam int PSUM_W = FRAC_W + VEL_W + 2;

  localparam logic [POS_W-1:0]         POS_CENTER = POS_W'(8 << FRAC_W);
  localparam logic [POS_W-1:0]         POS_MAX    = '1;
  localparam logic signed [PSUM_W-1:0] POS_LIMIT  = PSUM_W'((16 << FRAC_W) - 1);
  localparam logic signed [SUM_W-1:0]  VMAX_P     = SUM_W'(VMAX);
  localparam logic signed [SUM_W-1:0]  VMAX_N     = -VMAX_P;

`ifdef DEADZONE_EN
  localparam logic signed [15:0] DZ_HI = 16'(DEADZONE);
  localparam logic signed [15:0] DZ_LO = 16'(-DEADZONE);
`else
  localparam int unused_deadzone = DEADZONE;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    VEL,
    POS,
    RENDER,
    COMMIT
  } state_t;

  state_t                    state_q, state_d;
  logic [3:0]                row_q, row_d;
  logic [31:0]               hold_q, hold_d;
  logic signed [15:0]        ax_q, ax_d, ay_q, ay_d;
  logic signed [VEL_W-1:0]   vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic [POS_W-1:0]          pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [255:0]              shadow_q, shadow_d;
  logic [255:0]              matrix_q, matrix_d;
  logic                      matrix_valid_q, matrix_valid_d;
  logic                      busy_q, busy_d;

  // Only the two accel words are used; the rest of the IMU record is ignored.
  logic unused_imu_bits;
  assign unused_imu_bits = ^imu_data[63:0];

  // One velocity update for one axis. All terms are widened before the add,
  // so extreme accel cannot wrap before the saturation step.
  function automatic logic signed [VEL_W-1:0] vel_step(
    input logic signed [VEL_W-1:0] v,
    input logic signed [15:0]      a
  );
    logic signed [15:0]      a_shift;
    logic signed [SUM_W-1:0] v_ext;
    logic signed [SUM_W-1:0] a_ext;
    logic signed [SUM_W-1:0] sum;
    a_shift = a >>> ACCEL_SHIFT;
    v_ext   = SUM_W'(v);
    a_ext   = SUM_W'(a_shift);
    sum     = v_ext + a_ext;
`ifdef DEADZONE_EN
    if (a <= DZ_HI && a >= DZ_LO) begin
      sum = v_ext - (v_ext >>> 2);
    end
`endif
    if (sum > VMAX_P) begin
      sum = VMAX_P;
    end else if (sum < VMAX_N) begin
      sum = VMAX_N;
    end
    return VEL_W'(sum);
  endfunction

  // One position update for one axis. If the ball hits a wall, it stops at
  // the wall and bounces back at half speed.
  function automatic void pos_step(
    input  logic [POS_W-1:0]        p,
    input  logic signed [VEL_W-1:0] v,
    output logic [POS_W-1:0]        p_n,
    output logic signed [VEL_W-1:0] v_n
  );
    logic signed [PSUM_W-1:0] sum;
    sum = PSUM_W'($signed({1'b0, p})) + PSUM_W'(v);
    if (sum < 0) begin
      p_n = '0;
      v_n = -(v >>> 1);
    end else if (sum > POS_LIMIT) begin
      p_n = POS_MAX;
      v_n = -(v >>> 1);
    end else begin
      p_n = POS_W'(sum);
      v_n = v;
    end
  endfunction

  // Frame sequencer. In order, it latches accel, updates velocity, updates
  // position, renders 16 rows into the shadow buffer, then commits. A
  // frame_tick is accepted only in IDLE or on the commit edge. While a frame
  // is in flight, extra ticks are dropped.
  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    hold_d         = imu_valid ? imu_data[95:64] : hold_q;
    ax_d           = ax_q;
    ay_d           = ay_q;
    vel_x_d        = vel_x_q;
    vel_y_d        = vel_y_q;
    pos_x_d        = pos_x_q;
    pos_y_d        = pos_y_q;
    shadow_d       = shadow_q;
    matrix_d       = matrix_q;
    matrix_valid_d = 1'b0;
    busy_d         = busy_q;

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = LATCH;
          busy_d  = 1'b1;
        end
      end
      LATCH: begin
        ax_d    = hold_q[31:16];
        ay_d    = hold_q[15:0];
        state_d = VEL;
      end
      VEL: begin
        vel_x_d = vel_step(vel_x_q, ax_q);
        vel_y_d = vel_step(vel_y_q, ay_q);
        state_d = POS;
      end
      POS: begin
        pos_step(pos_x_q, vel_x_q, pos_x_d, vel_x_d);
        pos_step(pos_y_q, vel_y_q, pos_y_d, vel_y_d);
        row_d   = 4'd0;
        state_d = RENDER;
      end
      RENDER: begin
        shadow_d[{row_q, 4'b0000} +: 16] =
          (row_q == pos_y_q[POS_W-1:FRAC_W]) ? (16'd1 << pos_x_q[POS_W-1:FRAC_W]) : 16'd0;
        row_d = row_q + 4'd1;
        if (row_q == 4'd15) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        matrix_d       = shadow_q;
        matrix_valid_d = 1'b1;
        if (frame_tick) begin
          state_d = LATCH;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers. Reset puts the ball at rest in the centre of the matrix.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      row_q          <= 4'd0;
      hold_q         <= '0;
      ax_q           <= '0;
      ay_q           <= '0;
      vel_x_q        <= '0;
      vel_y_q        <= '0;
      pos_x_q        <= POS_CENTER;
      pos_y_q        <= POS_CENTER;
      shadow_q       <= '0;
      matrix_q       <= '0;
      matrix_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      hold_q         <= hold_d;
      ax_q           <= ax_d;
      ay_q           <= ay_d;
      vel_x_q        <= vel_x_d;
      vel_y_q        <= vel_y_d;
      pos_x_q        <= pos_x_d;
      pos_y_q        <= pos_y_d;
      shadow_q       <= shadow_d;
      matrix_q       <= matrix_d;
      matrix_valid_q <= matrix_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign matrix       = matrix_q;
  assign matrix_valid = matrix_valid_q;
  assign busy         = busy_q;

endmodule

// File: doc/imu_ball_renderer.md
Name: imu_ball_renderer

Overview:
Upstream stage of the LED-strip driver. It integrates IMU acceleration into a ball position on the 16x16 matrix once per frame and renders that position into the 256-bit matrix bitmap the driver consumes. The bitmap is double-buffered, so the driver never sees a half-rendered frame.

Parameters:
FRAC_W, 8, fractional bits of the position (position is unsigned Q4.FRAC_W, range 0..(16<<FRAC_W)-1)
VEL_W, 12, signed velocity width in position LSBs per frame
ACCEL_SHIFT, 6, arithmetic right shift applied to raw accel before adding to velocity
VMAX, 255, velocity saturation magnitude (velocity is clamped to -VMAX..+VMAX)
DEADZONE, 512, raw accel magnitude treated as zero (used only with DEADZONE_EN)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
imu_data  in  96  [95:80] accel X (signed, drives column), [79:64] accel Y (signed, drives row), [63:0] unused
imu_valid  in  1  when high, imu_data is captured into the hold register that edge
frame_tick  in  1  single-cycle request to compute a new frame
matrix  out  256  committed bitmap, bit (row*16+col) = pixel lit
matrix_valid  out  1  one-cycle pulse on the edge matrix updates
busy  out  1  high while a frame is being computed

Behaviour:
- Reset (asynchronous, any state): matrix=0, matrix_valid=0, busy=0, hold register=0, shadow=0, pos_x=pos_y=8<<FRAC_W, vel_x=vel_y=0, state=IDLE.
- Hold register: captures imu_data on every edge with imu_valid high, in any state. Frame math always uses the hold register value latched in LATCH.
- FSM: IDLE -> LATCH -> VEL -> POS -> RENDER(x16) -> COMMIT -> IDLE.
- IDLE: frame_tick high at edge k -> LATCH; busy high from k+1. frame_tick in any other state is ignored, not queued.
- LATCH: snapshot ax, ay from the hold register.
- VEL, per axis: v' = sat(v + (a >>> ACCEL_SHIFT), +/-VMAX). Sign-extend all terms to at least VEL_W+2 bits before adding.
- POS, per axis: p' = p + v', computed signed with at least FRAC_W+VEL_W+2 bits.
  - p' < 0: p=0, v = -(v' >>> 1).
  - p' > (16<<FRAC_W)-1: p = max, v = -(v' >>> 1).
  - Otherwise p=p', v=v'.
- RENDER: 16 cycles, one row per cycle, row r = 0..15. The shadow row is written with a single 1 at col = pos_x>>FRAC_W if r == pos_y>>FRAC_W, else zeros.
- COMMIT: matrix <= shadow, matrix_valid=1 for this cycle only, busy=0.
- Latency: frame_tick at edge k -> matrix updated and matrix_valid high at edge k+20, busy low the same edge. The next frame_tick is accepted at edge k+20 or later.
- matrix holds its value between commits.
- Exactly one pixel is lit after any commit.

Optional Feature:
DEADZONE_EN
- Defined: in VEL, any axis with |a| <= DEADZONE uses a=0, and that axis's velocity also decays v' = v - (v >>> 2), toward zero (friction).
- Undefined: raw accel is used unmodified and there is no decay. DEADZONE is unused.

Test Plan:
- Reset, imu_valid never asserted, frame_tick pulse -> at +20 cycles matrix has only bit 136 set (row 8, col 8); matrix_valid high exactly 1 cycle; busy high for cycles +1..+19.
- imu_data ax=+4096, ay=0 with imu_valid, then 4 frames -> vel_x 64, 128, 192, 255 (saturated); pos_x 2112, 2240, 2432, 2687 -> final lit bit = 8*16+10 = 138.
- ax=+32767 held until pos_x clamps at 4095 -> vel_x becomes -127 that frame; lit col 15. Then ax=0 -> the next frame moves left, pos_x=3968, col 15.
- frame_tick re-pulsed at +5 and +19 during busy -> ignored: exactly one matrix_valid pulse, at +20. A pulse at +20 starts a new frame whose commit is at +40.
- reset asserted mid-RENDER (cycle +10) -> matrix=0, busy=0, matrix_valid=0 immediately (asynchronous); next frame renders bit 136.
- DEADZONE_EN, ax=500 -> pos_x stays 2048 across 3 frames. Without the macro, ax=500 -> vel_x=7, pos_x 2055 after frame 1.
